cs_rr_arbiter: RTL and testbench
================================

Name: cs_rr_arbiter

Overview:
- Shares one 3-to-8 chip-select decode resource among 8 requesters.
- Round-robin arbitration selects one requester and drives a registered 3-bit select code plus 74x138-style active-low one-hot select lines, gated by an enable.
- Sits between bus masters/peripheral request lines and the decoded chip-select fabric of the lab datapath.
- Enforces a bounded hold time per grant and one idle gap cycle between grants.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per grant; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable, the equivalent of G1 high with G2A_n/G2B_n low; low blocks new grants and ends an active grant.
- req  input  8  level requests; req[i] is held high for as long as requester i wants the resource.
- grant_code  output  3  registered binary index of the granted requester; 0 when no grant is active.
- grant_valid  output  1  high while in GRANT.
- y_n  output  8  active-low one-hot select; y_n[grant_code]=0 in GRANT, 8'hFF otherwise.
- busy  output  1  high in GRANT or GAP.
- timeout  output  1  one-cycle pulse when a grant is forcibly ended at MAX_HOLD.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, grant_code=0, grant_valid=0, y_n=8'hFF, busy=0, timeout=0.
  - last pointer=3'd7, so requester 0 has first priority.
  - hold_cnt=0.
- Reset asserted mid-grant drops the grant immediately; it does not wait for a clock edge.
- All outputs are registered; none is combinational from req or en.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0, pick the winner: the first set bit of req, searching upward from (last+1) mod 8 and wrapping.
  - Next cycle: state=GRANT, grant_code=winner, y_n[winner]=0, grant_valid=1, busy=1, hold_cnt=0.
  - Latency from request to grant is 1 clock edge.
  - Otherwise stay in IDLE.
- GRANT, evaluated in priority order on each edge:
  - If en=0 or req[grant_code]=0: go to GAP, timeout=0.
  - Else if hold_cnt==MAX_HOLD-1: go to GAP and pulse timeout=1 for that one cycle.
  - Else: hold_cnt increments and the state stays in GRANT.
  - On leaving GRANT: last<=grant_code.
  - A granted requester holds the resource for at most MAX_HOLD cycles.
- GAP:
  - Lasts exactly one cycle: y_n=8'hFF, grant_valid=0, grant_code=0, busy=1.
  - Next state is always IDLE.
  - Minimum spacing between two grants is 2 idle-select cycles (GAP + IDLE).
- Requests that change on other lines during GRANT do not affect the current grant.
- Round-robin fairness: after requester k is served, requester k has the lowest priority at the next arbitration.
- A requester that timed out is treated like any other: it re-competes in IDLE at lowest priority.
- Simultaneous drop of req[grant_code] and reaching MAX_HOLD-1 counts as a normal release; timeout stays 0.
- en falling in the same cycle as an IDLE arbitration: no grant is issued.
- Invariant: y_n has at most one zero bit at all times. When grant_valid=1, y_n equals ~(8'b1 << grant_code).

Test Plan:
- Reset with req=8'hFF, then release rst_n with en=1: the edge after release gives GRANT with grant_code=0 and y_n=8'hFE. Drop req[0]: GAP, then IDLE, then grant_code=1 and y_n=8'hFD.
- Round robin with req held at 8'b1000_0100, each grant released after 3 cycles by pulsing its req low: the grant sequence is 2, 7, 2, 7, with a GAP+IDLE pair of y_n=8'hFF between each grant.
- Timeout with MAX_HOLD=16 and req[5] held high: y_n=8'hDF for exactly 16 cycles, then timeout=1 for one cycle in GAP. With req[3] also high, the next grant is 3, not 5.
- Drive en=0 during a grant of requester 4 at its 3rd cycle: the next cycle is GAP with y_n=8'hFF and timeout=0. While en=0, nothing is granted even with req=8'hFF.
- Assert rst_n=0 asynchronously mid-GRANT of requester 6: y_n goes to 8'hFF and grant_valid to 0 before the next clock edge. After release, last=7, so requester 0 wins first.
- Release req[1] in the same cycle that hold_cnt reaches MAX_HOLD-1: timeout stays 0 and the state goes to GAP normally.

Source files
------------

// File: rtl/cs_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// cs_rr_arbiter_if
//   Request/grant bundle between the requesting side and the chip-select
//   round-robin arbiter.
//
//   Signals:
//     en          global enable (G1 high, G2A_n/G2B_n low equivalent)
//     req[7:0]    level requests, one per requester
//     grant_code  registered binary index of the granted requester (0 if none)
//     grant_valid high while a grant is active
//     y_n[7:0]    74x138-style active-low one-hot select lines
//     busy        high while a grant or the post-grant gap is in progress
//     timeout     one-cycle pulse when a grant is cut off at the hold limit
//
//   Modports:
//     master : the requesting side (drives en/req, observes the grant)
//     slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface cs_rr_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic [2:0] grant_code;
  logic       grant_valid;
  logic [7:0] y_n;
  logic       busy;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  grant_code,
    input  grant_valid,
    input  y_n,
    input  busy,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output grant_code,
    output grant_valid,
    output y_n,
    output busy,
    output timeout
  );
endinterface : cs_rr_arbiter_if

// File: rtl/cs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cs_rr_arbiter
//   Shares one 3-to-8 chip-select decode among 8 requesters using round-robin
//   arbitration. The winner's index is registered as grant_code and decoded to
//   an active-low one-hot y_n. Each grant lasts at most MAX_HOLD cycles and is
//   always followed by one GAP cycle and one IDLE cycle before the next grant.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    cs_rr_arbiter_if.slave (en, req in; grant_code, grant_valid,
//            y_n, busy, timeout out -- all outputs registered)
//
//   Parameters:
//     MAX_HOLD  maximum consecutive GRANT cycles per grant (2..255)
//     CNT_W     hold counter width; 2**CNT_W must exceed MAX_HOLD
// -----------------------------------------------------------------------------
module cs_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cs_rr_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Counter value seen during the last permitted GRANT cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [2:0]       last_q,        last_d;
  logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic [2:0]       grant_code_q,  grant_code_d;
  logic             grant_valid_q, grant_valid_d;
  logic [7:0]       y_n_q,         y_n_d;
  logic             busy_q,        busy_d;
  logic             timeout_q,     timeout_d;

  // Round-robin winner search results.
  logic             win_found;
  logic [2:0]       win_idx;

  // ---------------------------------------------------------------------------
  // Winner search: first set request bit starting at (last+1) mod 8 and
  // wrapping, so the most recently served requester has the lowest priority.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      if (!win_found && bus.req[3'(int'(last_q) + i)]) begin
        win_found = 1'b1;
        win_idx   = 3'(int'(last_q) + i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    hold_cnt_d   = hold_cnt_q;
    grant_code_d = grant_code_q;
    timeout_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // en low in the arbitration cycle suppresses the grant entirely.
        if (bus.en && win_found) begin
          state_d      = ST_GRANT;
          grant_code_d = win_idx;
          hold_cnt_d   = '0;
        end else begin
          grant_code_d = 3'd0;
        end
      end

      ST_GRANT: begin
        // A release (en low or request dropped) takes priority over the
        // hold limit, so a simultaneous drop never reports a timeout.
        if (!bus.en || !bus.req[grant_code_q]) begin
          state_d      = ST_GAP;
          last_d       = grant_code_q;
          grant_code_d = 3'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_GAP;
          last_d       = grant_code_q;
          grant_code_d = 3'd0;
          timeout_d    = 1'b1;
        end else begin
          hold_cnt_d   = hold_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        state_d      = ST_IDLE;
        grant_code_d = 3'd0;
      end

      default: begin
        state_d      = ST_IDLE;
        grant_code_d = 3'd0;
      end
    endcase

    // Outputs are a function of the state being entered, so they register
    // alongside it and nothing reaches the pins combinationally.
    grant_valid_d = (state_d == ST_GRANT);
    busy_d        = (state_d != ST_IDLE);
    y_n_d         = grant_valid_d ? ~(8'b1 << grant_code_d) : 8'hFF;
  end

  // ---------------------------------------------------------------------------
  // Registers. Asynchronous reset drops any active grant immediately.
  // last resets to 7 so requester 0 has first priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_q        <= 3'd7;
      hold_cnt_q    <= '0;
      grant_code_q  <= 3'd0;
      grant_valid_q <= 1'b0;
      y_n_q         <= 8'hFF;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      last_q        <= last_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_code_q  <= grant_code_d;
      grant_valid_q <= grant_valid_d;
      y_n_q         <= y_n_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.grant_code  = grant_code_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.y_n         = y_n_q;
  assign bus.busy        = busy_q;
  assign bus.timeout     = timeout_q;

endmodule : cs_rr_arbiter

// File: tb/tb_cs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cs_rr_arbiter
//   Directed bench for cs_rr_arbiter. Each step drives inputs at the falling
//   edge, pushes the output expected after the next rising edge onto a
//   scoreboard queue, then pops and compares at the following falling edge.
// -----------------------------------------------------------------------------
module tb_cs_rr_arbiter;

  localparam int MAX_HOLD = 16;

  typedef struct {
    string      tag;
    logic [2:0] code;
    logic       valid;
    logic [7:0] y_n;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  cs_rr_arbiter_if bus ();

  cs_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Expected-output records, written from the specification's point of view.
  task automatic push_grant(input string tag, input int k);
    exp_t e;
    e.tag = tag; e.code = 3'(k); e.valid = 1'b1; e.busy = 1'b1; e.timeout = 1'b0;
    e.y_n = 8'hFF;
    e.y_n[k] = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_gap(input string tag, input logic to);
    exp_t e;
    e.tag = tag; e.code = 3'd0; e.valid = 1'b0; e.y_n = 8'hFF; e.busy = 1'b1; e.timeout = to;
    sb.push_back(e);
  endtask

  task automatic push_idle(input string tag);
    exp_t e;
    e.tag = tag; e.code = 3'd0; e.valid = 1'b0; e.y_n = 8'hFF; e.busy = 1'b0; e.timeout = 1'b0;
    sb.push_back(e);
  endtask

  // Direct comparison of the idle/reset output pattern, no clock edge.
  task automatic check_idle_now(input string tag);
    check({tag, ".code"},    8'(bus.grant_code), 8'd0);
    check({tag, ".valid"},   8'(bus.grant_valid), 8'd0);
    check({tag, ".y_n"},     bus.y_n, 8'hFF);
    check({tag, ".busy"},    8'(bus.busy), 8'd0);
    check({tag, ".timeout"}, 8'(bus.timeout), 8'd0);
  endtask

  // One rising edge, then pop the scoreboard and compare at the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".code"},    8'(bus.grant_code), 8'(e.code));
    check({e.tag, ".valid"},   8'(bus.grant_valid), 8'(e.valid));
    check({e.tag, ".y_n"},     bus.y_n, e.y_n);
    check({e.tag, ".busy"},    8'(bus.busy), 8'(e.busy));
    check({e.tag, ".timeout"}, 8'(bus.timeout), 8'(e.timeout));
  endtask

  initial begin
    int k;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.req = 8'hFF;

    // ---- reset state, then first grant goes to requester 0 ----
    #12;
    check_idle_now("reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_grant("first_g0", 0);    tick();
    bus.req = 8'hFE;
    push_gap("drop0_gap", 1'b0);  tick();
    push_idle("drop0_idle");      tick();
    push_grant("next_g1", 1);     tick();
    bus.req = 8'h00;
    push_gap("rel1_gap", 1'b0);   tick();
    push_idle("rel1_idle");       tick();

    // ---- round robin between requesters 2 and 7 ----
    bus.req = 8'b1000_0100;
    for (int i = 0; i < 4; i++) begin
      k = (i % 2 == 0) ? 2 : 7;
      push_grant($sformatf("rr%0d_c1", i), k); tick();
      push_grant($sformatf("rr%0d_c2", i), k); tick();
      push_grant($sformatf("rr%0d_c3", i), k); tick();
      bus.req = 8'b1000_0100 & ~(8'b1 << k);
      push_gap($sformatf("rr%0d_gap", i), 1'b0); tick();
      bus.req = 8'b1000_0100;
      push_idle($sformatf("rr%0d_idle", i)); tick();
    end
    bus.req = 8'h00;
    push_idle("rr_quiet"); tick();

    // ---- timeout on requester 5; requester 3 joins mid-grant ----
    bus.req = 8'h20;
    push_grant("to5_c1", 5); tick();
    bus.req = 8'h28;
    for (int c = 2; c <= MAX_HOLD; c++) begin
      push_grant($sformatf("to5_c%0d", c), 5); tick();
    end
    push_gap("to5_gap", 1'b1);  tick();
    push_idle("to5_idle");      tick();
    push_grant("after_to_g3", 3); tick();
    bus.req = 8'h00;
    push_gap("rel3_gap", 1'b0); tick();
    push_idle("rel3_idle");     tick();

    // ---- en dropped at the third cycle of a grant to requester 4 ----
    bus.req = 8'h10;
    push_grant("en4_c1", 4); tick();
    push_grant("en4_c2", 4); tick();
    push_grant("en4_c3", 4); tick();
    bus.en = 1'b0;
    push_gap("en4_gap", 1'b0); tick();
    bus.req = 8'hFF;
    push_idle("en_off_idle0"); tick();
    push_idle("en_off_idle1"); tick();
    push_idle("en_off_idle2"); tick();
    bus.req = 8'h00;
    bus.en  = 1'b1;
    push_idle("en_on_quiet");  tick();

    // ---- asynchronous reset in the middle of a grant to requester 6 ----
    bus.req = 8'h40;
    push_grant("rst6_c1", 6); tick();
    push_grant("rst6_c2", 6); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_now("async_rst");
    bus.req = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_grant("post_rst_g0", 0); tick();
    bus.req = 8'h00;
    push_gap("rel0_gap", 1'b0);   tick();
    push_idle("rel0_idle");       tick();

    // ---- release coinciding with the last permitted hold cycle ----
    bus.req = 8'h02;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      push_grant($sformatf("edge1_c%0d", c), 1); tick();
    end
    bus.req = 8'h00;
    push_gap("edge1_gap", 1'b0); tick();
    push_idle("edge1_idle");     tick();

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cs_rr_arbiter
